sprite_addr_gen: RTL and testbench
==================================

// Module: sprite_addr_gen
// PURPOSE
//  Parametrised sprite ROM address generator for the VGA pipeline.
//  - Per video frame, walks a SPR_W x SPR_H sprite window at a latched (pos_x,pos_y).
//  - Emits a ROM read enable and a linear address, with a LEAD-pixel lead to cover ROM latency.
//  - Adds multi-frame animation, frame-synchronous position latching and explicit row/column tracking.
//  - One instance per sprite type: invader, player, pause banner, etc.
// PARAMETERS
//  CORDW    10  width of pixel/line/position coordinates
//  SPR_W    32  sprite width in pixels
//  SPR_H    16  sprite height in lines
//  FRAMES    2  animation frames stored back-to-back in ROM (>=1)
//  ADDRW    15  ROM address width; FRAMES*SPR_W*SPR_H <= 2**ADDRW
//  LEAD      2  pixels by which rden/addr precede the on-screen pixel
//  ANIM_DIV 30  video frames per animation step (>=1)
// PORTS
//  clk          in   1      pixel clock
//  rst_n        in   1      reset, synchronous, active-low
//  pixel        in   CORDW  current horizontal coordinate
//  line         in   CORDW  current vertical coordinate
//  frame_start  in   1      one-cycle pulse at start of each video frame (in vblank)
//  pos_x        in   CORDW  sprite left edge; sampled only on frame_start
//  pos_y        in   CORDW  sprite top edge; sampled only on frame_start
//  enable       in   1      sprite visible; sampled only on frame_start
//  anim_en      in   1      animation advance permitted
//  hflip        in   1      horizontal mirror request; ignored unless SPRITE_HFLIP_EN
//  rden         out  1      ROM read enable (registered)
//  addr         out  ADDRW  ROM address (registered)
//  frame_idx    out  clog2(FRAMES)  current animation frame
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk):
//   - rden=0, addr=0, frame_idx=0, anim counter=0, row=col=0, state=IDLE.
//   - Holds until the next frame_start, including when asserted mid-frame.
//  States:
//   - IDLE: wait for frame_start.
//   - WAIT: frame_start latches pos_x, pos_y, enable; row=0, col=0. enable=0 latched -> IDLE.
//   - DRAW: line in [py, py+SPR_H-1] and pixel == px-LEAD -> DRAW.
//   - DONE: entered after the last pixel of row SPR_H-1; stays until frame_start.
//  Window start: xs = px-LEAD, computed in CORDW+1 bits; px < LEAD clamps xs to 0.
//  In DRAW:
//   - rden=1 for SPR_W consecutive cycles per row; col counts 0..SPR_W-1.
//   - After col SPR_W-1: rden=0, col=0, row+1, back to WAIT for the next line's xs.
//   - After row SPR_H-1 -> DONE.
//  Address (registered, same cycle as rden):
//   - addr = frame_idx*SPR_W*SPR_H + row*SPR_W + col, mod 2**ADDRW.
//   - Computed incrementally with a row-base register, not a multiplier.
//  Latency: rden/addr go high on the cycle after pixel==xs is observed.
//   - Data returned after ROM latency aligns with pixel==px when LEAD matches that latency.
//  Sprite clipped by screen bottom: remaining rows never drawn; DONE not reached.
//   - Next frame_start restarts cleanly from row 0.
//  Animation:
//   - On frame_start with anim_en=1, the anim counter increments.
//   - At ANIM_DIV-1 the counter clears and frame_idx advances mod FRAMES (FRAMES=1 -> always 0).
//   - anim_en=0: counter and frame_idx hold.
//   - A new frame_idx takes effect for the frame that starts on that pulse.
//  Simultaneous events:
//   - frame_start has priority over any DRAW activity (aborts the row, rden=0 next cycle).
//   - rst_n has priority over frame_start.
//  pos_x/pos_y/enable changes between frame_start pulses have no effect (no tearing).
// CONFIGURATION
//  SPRITE_HFLIP_EN defined:
//   - hflip sampled on frame_start.
//   - If set: addr = base + row*SPR_W + (SPR_W-1-col); the row is read right-to-left.
//  SPRITE_HFLIP_EN undefined:
//   - hflip ignored, no mirror logic built.
//   - Addressing as above; port kept for a uniform interface.
// TESTING
//  1 Reset mid-DRAW, release: rden=0, addr=0, frame_idx=0; no rden until after the next frame_start.
//  2 pos=(100,50), W=32, H=16, LEAD=2:
//    - rden first high the cycle after pixel=98, line=50, with addr=0.
//    - 32-cycle bursts per row; last addr=511 on line 65; 512 rden cycles in total.
//  3 ANIM_DIV=2, FRAMES=2, anim_en=1:
//    - frame_idx toggles every 2nd frame_start.
//    - First addr of a frame-1 draw = 512; anim_en=0 freezes frame_idx.
//  4 Change pos_x 100->200 mid-frame: current frame still draws at 100; the next frame draws at 200.
//  5 pos_x=1 (< LEAD): window starts at pixel 0, no wrap.
//    - pos_y=470, screen 480: 10 rows drawn; next frame_start restarts at addr 0.
//  6 SPRITE_HFLIP_EN, hflip=1, frame 0: row 0 addr sequence 31,30..0; row 1 starts at 63.

Source files
------------

// File: rtl/sprite_addr_gen.sv
// Sprite ROM address generator for the VGA pipeline.
// Walks a SPR_W x SPR_H window once per video frame at a position latched on
// frame_start, issuing rden/addr LEAD pixels ahead of the on-screen pixel so
// ROM data lines up with the display. Animation frames are stored back-to-back
// in ROM; frame_idx steps every ANIM_DIV frame_start pulses while anim_en=1.
// Optional feature macro: SPRITE_HFLIP_EN (horizontal mirror using hflip).
module sprite_addr_gen #(
    parameter int CORDW    = 10,
    parameter int SPR_W    = 32,
    parameter int SPR_H    = 16,
    parameter int FRAMES   = 2,
    parameter int ADDRW    = 15,
    parameter int LEAD     = 2,
    parameter int ANIM_DIV = 30,
    localparam int FIW     = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CORDW-1:0] pixel,
    input  logic [CORDW-1:0] line,
    input  logic             frame_start,
    input  logic [CORDW-1:0] pos_x,
    input  logic [CORDW-1:0] pos_y,
    input  logic             enable,
    input  logic             anim_en,
    input  logic             hflip,
    output logic             rden,
    output logic [ADDRW-1:0] addr,
    output logic [FIW-1:0]   frame_idx
);

    localparam int ACW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int CW  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW  = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    localparam logic [ADDRW-1:0] FRAME_SZ = ADDRW'(SPR_W * SPR_H);
    localparam logic [ADDRW-1:0] ROW_SZ   = ADDRW'(SPR_W);
    localparam logic [CORDW:0]   LEAD_C   = (CORDW+1)'(LEAD);
    localparam logic [CORDW:0]   HGT_M1   = (CORDW+1)'(SPR_H - 1);
    localparam logic [CW-1:0]    LAST_COL = CW'(SPR_W - 1);
    localparam logic [RW-1:0]    LAST_ROW = RW'(SPR_H - 1);
    localparam logic [ACW-1:0]   LAST_CNT = ACW'(ANIM_DIV - 1);
    localparam logic [FIW-1:0]   LAST_FRM = FIW'(FRAMES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DRAW, DONE} state_t;

    state_t           state_q,      state_d;
    logic [CORDW-1:0] px_q,         px_d;
    logic [CORDW-1:0] py_q,         py_d;
    logic [RW-1:0]    row_q,        row_d;
    logic [CW-1:0]    col_q,        col_d;
    logic [ADDRW-1:0] row_base_q,   row_base_d;
    logic [ADDRW-1:0] frame_base_q, frame_base_d;
    logic [FIW-1:0]   frame_idx_q,  frame_idx_d;
    logic [ACW-1:0]   anim_cnt_q,   anim_cnt_d;
    logic             rden_q,       rden_d;
    logic [ADDRW-1:0] addr_q,       addr_d;

`ifdef SPRITE_HFLIP_EN
    logic             hf_q,         hf_d;
`else
    logic             unused_hflip;
    assign unused_hflip = hflip;
`endif

    logic [CORDW:0]   xs;
    logic [CORDW:0]   py_end;
    logic             in_rows;
    logic             at_xs;
    logic             go;
    logic [CW-1:0]    cur_col;
    logic [ADDRW-1:0] col_off;

    // Window geometry in CORDW+1 bits so px-LEAD and py+SPR_H-1 never wrap.
    always_comb begin
        xs      = ({1'b0, px_q} < LEAD_C) ? '0 : ({1'b0, px_q} - LEAD_C);
        py_end  = {1'b0, py_q} + HGT_M1;
        in_rows = ({1'b0, line} >= {1'b0, py_q}) && ({1'b0, line} <= py_end);
        at_xs   = ({1'b0, pixel} == xs);
    end

    // Next-state: frame_start latching/animation, then row/column walk.
    always_comb begin
        state_d      = state_q;
        px_d         = px_q;
        py_d         = py_q;
        row_d        = row_q;
        col_d        = col_q;
        row_base_d   = row_base_q;
        frame_base_d = frame_base_q;
        frame_idx_d  = frame_idx_q;
        anim_cnt_d   = anim_cnt_q;
        rden_d       = 1'b0;
        addr_d       = addr_q;
        go           = 1'b0;
        cur_col      = '0;
        col_off      = '0;
`ifdef SPRITE_HFLIP_EN
        hf_d         = hf_q;
`endif

        case (state_q)
            WAIT:    go = in_rows && at_xs;
            DRAW: begin
                go      = 1'b1;
                cur_col = col_q;
            end
            default: go = 1'b0;
        endcase

`ifdef SPRITE_HFLIP_EN
        col_off = hf_q ? ADDRW'(LAST_COL - cur_col) : ADDRW'(cur_col);
`else
        col_off = ADDRW'(cur_col);
`endif

        if (frame_start) begin
            // Frame base tracks frame_idx incrementally so no multiplier is needed.
            if (anim_en) begin
                if (anim_cnt_q == LAST_CNT) begin
                    anim_cnt_d = '0;
                    if (frame_idx_q == LAST_FRM) begin
                        frame_idx_d  = '0;
                        frame_base_d = '0;
                    end else begin
                        frame_idx_d  = frame_idx_q + FIW'(1);
                        frame_base_d = frame_base_q + FRAME_SZ;
                    end
                end else begin
                    anim_cnt_d = anim_cnt_q + ACW'(1);
                end
            end
            px_d       = pos_x;
            py_d       = pos_y;
            row_d      = '0;
            col_d      = '0;
            row_base_d = frame_base_d;
            state_d    = enable ? WAIT : IDLE;
`ifdef SPRITE_HFLIP_EN
            hf_d       = hflip;
`endif
        end else if (go) begin
            rden_d = 1'b1;
            addr_d = row_base_q + col_off;
            if (cur_col == LAST_COL) begin
                col_d      = '0;
                row_base_d = row_base_q + ROW_SZ;
                if (row_q == LAST_ROW) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + RW'(1);
                    state_d = WAIT;
                end
            end else begin
                col_d   = cur_col + CW'(1);
                state_d = DRAW;
            end
        end
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            px_q         <= '0;
            py_q         <= '0;
            row_q        <= '0;
            col_q        <= '0;
            row_base_q   <= '0;
            frame_base_q <= '0;
            frame_idx_q  <= '0;
            anim_cnt_q   <= '0;
            rden_q       <= 1'b0;
            addr_q       <= '0;
`ifdef SPRITE_HFLIP_EN
            hf_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            px_q         <= px_d;
            py_q         <= py_d;
            row_q        <= row_d;
            col_q        <= col_d;
            row_base_q   <= row_base_d;
            frame_base_q <= frame_base_d;
            frame_idx_q  <= frame_idx_d;
            anim_cnt_q   <= anim_cnt_d;
            rden_q       <= rden_d;
            addr_q       <= addr_d;
`ifdef SPRITE_HFLIP_EN
            hf_q         <= hf_d;
`endif
        end
    end

    assign rden      = rden_q;
    assign addr      = addr_q;
    assign frame_idx = frame_idx_q;

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Scoreboard bench for sprite_addr_gen: the driver sweeps pixel/line and pushes
// the expected (line, pixel, addr) of every ROM read; a negedge monitor pops and
// compares whenever rden is high. Expected reads are enumerated directly from
// the sprite placement rules, one row per scanned line.
module tb_sprite_addr_gen;

    localparam int CORDW    = 10;
    localparam int SPR_W    = 32;
    localparam int SPR_H    = 16;
    localparam int FRAMES   = 2;
    localparam int ADDRW    = 15;
    localparam int LEAD     = 2;
    localparam int ANIM_DIV = 2;
    localparam int FIW      = 1;
    localparam int H_TOT    = 240;
    localparam int V_VIS    = 480;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CORDW-1:0] pixel, line, pos_x, pos_y;
    logic             frame_start, enable, anim_en, hflip;
    logic             rden;
    logic [ADDRW-1:0] addr;
    logic [FIW-1:0]   frame_idx;

    always #5 clk = ~clk;

    sprite_addr_gen #(
        .CORDW(CORDW), .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES),
        .ADDRW(ADDRW), .LEAD(LEAD), .ANIM_DIV(ANIM_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel(pixel), .line(line),
        .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y),
        .enable(enable), .anim_en(anim_en), .hflip(hflip),
        .rden(rden), .addr(addr), .frame_idx(frame_idx)
    );

    typedef struct { int ln; int pix; int adr; } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_cnt = 0, m_fidx = 0;
    int l_px = 0, l_py = 0;
    bit l_en = 1'b0, l_hf = 1'b0;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_inputs();
        pos_x   = CORDW'($urandom_range(0, 1023));
        pos_y   = CORDW'($urandom_range(0, 1023));
        enable  = 1'($urandom_range(0, 1));
        hflip   = 1'($urandom_range(0, 1));
        anim_en = 1'($urandom_range(0, 1));
    endtask

    // Reset is applied for the current cycle; afterwards nothing is pending.
    task automatic apply_reset(string tag);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        sb.delete();
        m_cnt = 0; m_fidx = 0; l_en = 1'b0;
        check({tag, "_rden"}, int'(rden), 0);
        check({tag, "_addr"}, int'(addr), 0);
        check({tag, "_frame_idx"}, int'(frame_idx), m_fidx);
    endtask

    task automatic start_frame(int px, int py, bit en, bit hf, bit ae);
        pixel = '0; line = CORDW'(500);
        pos_x = CORDW'(px); pos_y = CORDW'(py);
        enable = en; hflip = hf; anim_en = ae;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        if (ae) begin
            m_cnt++;
            if (m_cnt == ANIM_DIV) begin
                m_cnt  = 0;
                m_fidx = (m_fidx + 1) % FRAMES;
            end
        end
        l_px = px; l_py = py; l_en = en; l_hf = hf;
        junk_inputs();
        check("frame_idx", int'(frame_idx), m_fidx);
    endtask

    // One scanned line; rst_pix >= 0 asserts reset while that pixel is shown.
    task automatic scan_line(int l, int rst_pix);
        int xs, off;
        if (l_en && l >= l_py && l < l_py + SPR_H) begin
            xs = (l_px < LEAD) ? 0 : l_px - LEAD;
            for (int c = 0; c < SPR_W; c++) begin
                off = c;
`ifdef SPRITE_HFLIP_EN
                if (l_hf) off = SPR_W - 1 - c;
`endif
                sb.push_back('{ln: l, pix: xs + 1 + c,
                    adr: (m_fidx * SPR_W * SPR_H + (l - l_py) * SPR_W + off) % (1 << ADDRW)});
            end
        end
        junk_inputs();
        for (int p = 0; p < H_TOT; p++) begin
            line  = CORDW'(l);
            pixel = CORDW'(p);
            if (p == rst_pix) apply_reset("mid_reset");
            else cyc();
        end
    endtask

    task automatic run_frame(int px, int py, bit en, bit hf, bit ae,
                             int rst_line = -1, int rst_pix = -1);
        int lo, hi;
        start_frame(px, py, en, hf, ae);
        lo = (py > 0) ? py - 1 : 0;
        hi = (py + SPR_H < V_VIS - 1) ? py + SPR_H : V_VIS - 1;
        for (int l = lo; l <= hi; l++)
            scan_line(l, (l == rst_line) ? rst_pix : -1);
        check("reads_left_over", sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: every rden cycle must match the next expected read.
    always @(negedge clk) begin
        if (rden === 1'b1) begin
            if (sb.size() == 0) begin
                check("rden_unexpected", int'(rden), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("read_line", int'(line), e.ln);
                check("read_pixel", int'(pixel), e.pix);
                check("read_addr", int'(addr), e.adr);
            end
        end
    end

    initial begin
        rst_n = 1'b0; frame_start = 1'b0;
        pixel = '0; line = '0;
        pos_x = '0; pos_y = '0; enable = 1'b0; anim_en = 1'b0; hflip = 1'b0;
        repeat (2) cyc();
        apply_reset("reset");

        // No frame_start yet: a full sweep over a plausible window stays silent.
        scan_line(50, -1);

        // Basic draw at (100,50), then the animation step to frame 1 (base 512).
        run_frame(100, 50, 1'b1, 1'b0, 1'b1);
        run_frame(100, 50, 1'b1, 1'b0, 1'b1);
        // anim_en=0 freezes frame_idx; new position takes effect this frame.
        run_frame(200, 60, 1'b1, 1'b0, 1'b0);
        // Reset in the middle of a row; remaining lines must stay silent.
        run_frame(100, 50, 1'b1, 1'b0, 1'b1, 55, 110);
        // pos_x below LEAD, clipped at the screen bottom, then a clean restart.
        run_frame(1, 470, 1'b1, 1'b0, 1'b0);
        run_frame(1, 5, 1'b1, 1'b0, 1'b0);
        // Disabled sprite, and a mirror request.
        run_frame(100, 50, 1'b0, 1'b0, 1'b1);
        run_frame(50, 100, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 5; i++)
            run_frame($urandom_range(0, 200), $urandom_range(0, 479),
                      ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
